// File: rtl/comparator_bist.sv
// Exhaustive self-test sequencer for an equality comparator: sweeps every {x,y} pair, checks z after LAT+1 cycles.
// COMPARATOR_BIST_FAILCAP_EN adds capture of the first failing vector (fail_valid/fail_x/fail_y).
module comparator_bist #(
  parameter int WIDTH = 1,
  parameter int LAT   = 0,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef COMPARATOR_BIST_FAILCAP_EN
  ,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_x,
  output logic [WIDTH-1:0] fail_y
`endif
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LAT > 0) ? LAT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [VW-1:0]    vec_inc;
  logic             mismatch;

`ifdef COMPARATOR_BIST_FAILCAP_EN
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fx_q, fx_d;
  logic [WIDTH-1:0] fy_q, fy_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= '0;
`ifdef COMPARATOR_BIST_FAILCAP_EN
      fv_q    <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
`ifdef COMPARATOR_BIST_FAILCAP_EN
      fv_q    <= fv_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    err_d    = err_q;
    vec_inc  = vec_q + 1'b1;
    mismatch = (z != (x_q == y_q));
`ifdef COMPARATOR_BIST_FAILCAP_EN
    fv_d     = fv_q;
    fx_d     = fx_q;
    fy_d     = fy_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          x_d     = '0;
          y_d     = '0;
          err_d   = '0;
`ifdef COMPARATOR_BIST_FAILCAP_EN
          fv_d    = 1'b0;
          fx_d    = '0;
          fy_d    = '0;
`endif
        end
      end
      DRIVE: begin
        if (LAT > 0) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = CHECK;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      CHECK: begin
        if (mismatch && (err_q != {ERR_W{1'b1}})) err_d = err_q + 1'b1;
`ifdef COMPARATOR_BIST_FAILCAP_EN
        // Only the first failing vector of a run is kept.
        if (mismatch && !fv_q) begin
          fv_d = 1'b1;
          fx_d = x_q;
          fy_d = y_q;
        end
`endif
        if (vec_q == {VW{1'b1}}) begin
          state_d = DONE;
          x_d     = '0;
          y_d     = '0;
        end else begin
          state_d = DRIVE;
          vec_d   = vec_inc;
          x_d     = vec_inc[VW-1:WIDTH];
          y_d     = vec_inc[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign x         = x_q;
  assign y         = y_q;
  assign busy      = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;

`ifdef COMPARATOR_BIST_FAILCAP_EN
  assign fail_valid = fv_q;
  assign fail_x     = fx_q;
  assign fail_y     = fy_q;
`endif

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist: four instances with different WIDTH/LAT/ERR_W share stimulus,
// each facing a behavioural comparator whose fault mode is picked per run.
module tb_comparator_bist;

  localparam int W_P [4] = '{1, 1, 2, 2};
  localparam int L_P [4] = '{0, 0, 1, 0};
  localparam int E_P [4] = '{8, 2, 8, 8};

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   mode;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic [0:0] xa, ya, xb, yb;
  logic [1:0] xc, yc, xd, yd;
  logic       za, zb, zc, zd;
  logic [3:0] busy_v, done_v, pass_v;
  logic [7:0] err_a, err_c, err_d;
  logic [1:0] err_b;
  logic [7:0] err_v [4];
  logic [3:0] vec_v [4];
  logic [3:0] fv_v;
  logic [3:0] fxy_v [4];

  // Modes: 0 ideal, 1 stuck at 0, 2 inverted, 3 one-register z, 4 two-register z.
  function automatic logic mock_z(input logic eq, input logic p1, input logic p2, input int m);
    case (m)
      1: return 1'b0;
      2: return !eq;
      3: return p1;
      4: return p2;
      default: return eq;
    endcase
  endfunction

  logic pa1, pa2, pb1, pb2, pc1, pc2, pd1, pd2;
  always @(posedge clk) begin
    pa1 <= (xa == ya); pa2 <= pa1;
    pb1 <= (xb == yb); pb2 <= pb1;
    pc1 <= (xc == yc); pc2 <= pc1;
    pd1 <= (xd == yd); pd2 <= pd1;
  end
  assign za = mock_z(xa == ya, pa1, pa2, mode);
  assign zb = mock_z(xb == yb, pb1, pb2, mode);
  assign zc = mock_z(xc == yc, pc1, pc2, mode);
  assign zd = mock_z(xd == yd, pd1, pd2, mode);

`ifdef COMPARATOR_BIST_FAILCAP_EN
  logic       fva, fvb, fvc, fvd;
  logic [0:0] fxa, fya, fxb, fyb;
  logic [1:0] fxc, fyc, fxd, fyd;
  assign fv_v     = {fvd, fvc, fvb, fva};
  assign fxy_v[0] = {2'b00, fxa, fya};
  assign fxy_v[1] = {2'b00, fxb, fyb};
  assign fxy_v[2] = {fxc, fyc};
  assign fxy_v[3] = {fxd, fyd};
`else
  assign fv_v     = 4'b0000;
  assign fxy_v[0] = 4'h0;
  assign fxy_v[1] = 4'h0;
  assign fxy_v[2] = 4'h0;
  assign fxy_v[3] = 4'h0;
`endif

  comparator_bist #(.WIDTH(W_P[0]), .LAT(L_P[0]), .ERR_W(E_P[0])) u_a (
    .clk(clk), .rst(rst), .start(start), .x(xa), .y(ya), .z(za),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_a)
`ifdef COMPARATOR_BIST_FAILCAP_EN
    , .fail_valid(fva), .fail_x(fxa), .fail_y(fya)
`endif
  );
  comparator_bist #(.WIDTH(W_P[1]), .LAT(L_P[1]), .ERR_W(E_P[1])) u_b (
    .clk(clk), .rst(rst), .start(start), .x(xb), .y(yb), .z(zb),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_b)
`ifdef COMPARATOR_BIST_FAILCAP_EN
    , .fail_valid(fvb), .fail_x(fxb), .fail_y(fyb)
`endif
  );
  comparator_bist #(.WIDTH(W_P[2]), .LAT(L_P[2]), .ERR_W(E_P[2])) u_c (
    .clk(clk), .rst(rst), .start(start), .x(xc), .y(yc), .z(zc),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_c)
`ifdef COMPARATOR_BIST_FAILCAP_EN
    , .fail_valid(fvc), .fail_x(fxc), .fail_y(fyc)
`endif
  );
  comparator_bist #(.WIDTH(W_P[3]), .LAT(L_P[3]), .ERR_W(E_P[3])) u_d (
    .clk(clk), .rst(rst), .start(start), .x(xd), .y(yd), .z(zd),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(err_d)
`ifdef COMPARATOR_BIST_FAILCAP_EN
    , .fail_valid(fvd), .fail_x(fxd), .fail_y(fyd)
`endif
  );

  assign err_v[0] = err_a;
  assign err_v[1] = {6'b0, err_b};
  assign err_v[2] = err_c;
  assign err_v[3] = err_d;
  assign vec_v[0] = {2'b00, xa, ya};
  assign vec_v[1] = {2'b00, xb, yb};
  assign vec_v[2] = {xc, yc};
  assign vec_v[3] = {xd, yd};

  // ---------------- reference model ----------------
  // Vector k is {x,y} = k; before the first vector x=y=0, so "vector -1" compares equal.
  function automatic bit veq(input int k, input int w);
    if (k < 0) return 1'b1;
    return ((k >> w) == (k & ((1 << w) - 1)));
  endfunction

  // z value seen by the checker for vector k: a comparator with d register stages
  // shows, at the end of the LAT+2-cycle vector slot, the result for a vector
  // ceil((d-LAT-1)/(LAT+2)) slots earlier once d exceeds LAT+1.
  function automatic bit seen_z(input int k, input int w, input int l, input int m);
    int d;
    case (m)
      1: return 1'b0;
      2: return !veq(k, w);
      3, 4: begin
        d = m - 2;
        if (d <= l + 1) return veq(k, w);
        return veq(k - (d - l - 1 + l + 1) / (l + 2), w);
      end
      default: return veq(k, w);
    endcase
  endfunction

  function automatic int exp_err(input int i, input int m);
    int n = 0;
    int cap = (1 << E_P[i]) - 1;
    for (int k = 0; k < (1 << (2 * W_P[i])); k++)
      if (seen_z(k, W_P[i], L_P[i], m) != veq(k, W_P[i])) n++;
    return (n > cap) ? cap : n;
  endfunction

  function automatic int first_fail(input int i, input int m);
    for (int k = 0; k < (1 << (2 * W_P[i])); k++)
      if (seen_z(k, W_P[i], L_P[i], m) != veq(k, W_P[i])) return k;
    return -1;
  endfunction

  function automatic int run_len(input int i);
    return (1 << (2 * W_P[i])) * (L_P[i] + 2);
  endfunction

  // ---------------- scenarios ----------------
  // One run with all four instances; c counts rising edges since the start edge.
  task automatic run_check(input string name, input int m, input bit hold);
    int t, e, ff;
    mode = m;
    repeat ($urandom_range(2, 6)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int c = 0; c <= 50; c++) begin
      for (int i = 0; i < 4; i++) begin
        t  = run_len(i);
        e  = exp_err(i, m);
        ff = first_fail(i, m);
        if (c < t) begin
          checks++;
          if (busy_v[i] !== 1'b1 || done_v[i] !== 1'b0 || vec_v[i] !== 4'(c / (L_P[i] + 2))) begin
            errors++;
            $display("FAIL %s_seq inst%0d c=%0d: busy=%b done=%b xy=%h, want busy=1 done=0 xy=%h",
                     name, i, c, busy_v[i], done_v[i], vec_v[i], c / (L_P[i] + 2));
          end
        end else if (c == t) begin
          checks++;
          if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b1 || err_v[i] !== 8'(e) ||
              pass_v[i] !== (e == 0) || vec_v[i] !== 4'h0) begin
            errors++;
            $display("FAIL %s_done inst%0d: busy=%b done=%b err=%0d pass=%b xy=%h, want 0 1 %0d %b 0",
                     name, i, busy_v[i], done_v[i], err_v[i], pass_v[i], vec_v[i], e, (e == 0));
          end
`ifdef COMPARATOR_BIST_FAILCAP_EN
          checks++;
          if (fv_v[i] !== (ff >= 0) || fxy_v[i] !== 4'((ff >= 0) ? ff : 0)) begin
            errors++;
            $display("FAIL %s_failcap inst%0d: valid=%b xy=%h, want valid=%b xy=%h",
                     name, i, fv_v[i], fxy_v[i], (ff >= 0), (ff >= 0) ? ff : 0);
          end
`endif
        end else if (c == t + 1) begin
          checks++;
          if (hold) begin
            if (busy_v[i] !== 1'b1 || done_v[i] !== 1'b0 || err_v[i] !== 8'h0) begin
              errors++;
              $display("FAIL %s_restart inst%0d: busy=%b done=%b err=%0d, want 1 0 0",
                       name, i, busy_v[i], done_v[i], err_v[i]);
            end
          end else if (done_v[i] !== 1'b1 || err_v[i] !== 8'(e)) begin
            errors++;
            $display("FAIL %s_hold inst%0d: done=%b err=%0d, want 1 %0d",
                     name, i, done_v[i], err_v[i], e);
          end
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_cleared(input string name);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || pass_v[i] !== 1'b0 ||
          err_v[i] !== 8'h0 || vec_v[i] !== 4'h0 || fv_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s inst%0d: busy=%b done=%b pass=%b err=%0d xy=%h fv=%b, want all 0",
                 name, i, busy_v[i], done_v[i], pass_v[i], err_v[i], vec_v[i], fv_v[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
  endtask

  task automatic test_ideal();       run_check("ideal", 0, 1'b0);     endtask
  task automatic test_stuck_zero();  run_check("stuck0", 1, 1'b0);    endtask
  task automatic test_inverted();    run_check("inverted", 2, 1'b0);  endtask
  task automatic test_registered();  run_check("reg1", 3, 1'b0);      endtask
  task automatic test_two_stage();   run_check("reg2", 4, 1'b0);      endtask

  task automatic test_midrun_reset();
    int r = $urandom_range(4, 5);
    mode = 1;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (r) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("midrun_reset");
    rst = 1'b0;
    run_check("after_reset", 0, 1'b0);
  endtask

  task automatic test_start_held();
    run_check("held", 1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) run_check("random", $urandom_range(0, 4), 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 0;
    test_reset();
    test_ideal();
    test_stuck_zero();
    test_inverted();
    test_registered();
    test_two_stage();
    test_midrun_reset();
    test_start_held();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
